psum_collector: RTL
===================

# psum_collector

Drain-side companion to the systolic PE array: captures partial sums leaving the bottom row of a COLS-wide array, removes the one-cycle-per-column skew the array introduces, accumulates rows over multiple weight tiles into wider accumulators, and buffers completed rows in a small FIFO behind a valid/ready handshake toward the output writer. It is the consumer of `partial_sum_out` from the last PE of each column. It also gives the array controller a full flag for stalling.

## Interface
- WIDTH, 8: bit width of each PE partial sum.
- COLS, 4: number of array columns (≥2).
- ACC_WIDTH, 16: accumulator/output element width (≥ WIDTH).
- DEPTH, 4: output FIFO depth in rows (power of 2, ≥2).

- clk_in  input  1  clock; all state changes on rising edge.
- rst_in  input  1  synchronous, active-high reset.
- psum_in  input  COLS*WIDTH  bottom-row partial sums; column j in bits [j*WIDTH +: WIDTH].
- valid_in  input  1  column 0 holds a valid element this cycle.
- first_in  input  1  qualified by valid_in; row starts a new accumulation.
- last_in  input  1  qualified by valid_in; row completes the accumulation.
- out_data_out  output  COLS*ACC_WIDTH  FIFO head row; column j in bits [j*ACC_WIDTH +: ACC_WIDTH].
- out_valid_out  output  1  FIFO non-empty.
- out_ready_in  input  1  downstream accepts head row.
- full_out  output  1  FIFO holds DEPTH rows.
- overflow_out  output  1  sticky: completed row dropped because FIFO was full.

## Operation
- Skew: a row launched with valid_in in cycle t has column j on psum_in in cycle t+j. Only valid_in/first_in/last_in at cycle t qualify the row. psum_in column j outside its slot is don't-care.
- Deskew: column j passes through COLS-1-j registers. Column COLS-1 is used directly. valid/first/last pass through a COLS-1 stage shift register. The full aligned row plus its flags is present in cycle t+COLS-1.
- Accumulate at the edge ending cycle t+COLS-1, when the aligned row is valid:
  - sum_j = zero-extend(psum_j) if first, else acc_j + zero-extend(psum_j), wrapping mod 2^ACC_WIDTH.
  - acc_j <= sum_j.
  - If last: push {sum_0..sum_{COLS-1}} into the FIFO. first and last together form a single-pass row.
- Rows with neither flag accumulate only. A row with last but no prior first adds onto the existing acc.
- Back-to-back valid_in every cycle is supported; each row uses its own skew slot.
- FIFO:
  - Pop when out_valid_out && out_ready_in.
  - Push when a last row completes and either the FIFO is not full, or a pop occurs in the same cycle.
  - Otherwise drop the row and set overflow_out, which clears only on reset.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap mod DEPTH.
- full_out = (count == DEPTH). The controller must hold valid_in low while full_out is high or a row will be lost. The block itself never stalls.

## Timing
- Reset values: all deskew/flag registers 0, acc 0, FIFO empty.
- Outputs at reset: out_valid_out 0, out_data_out 0, full_out 0, overflow_out 0.
- Reset mid-operation discards in-flight and buffered rows. Rows launched before the reset never appear.
- Latency: row with last at cycle t → out_valid_out high in cycle t+COLS (FIFO previously empty), out_data_out valid the same cycle.
- out_data_out must be stable while out_valid_out is high and out_ready_in is low.
- Throughput: one row per cycle in, one row per cycle out.

## Test plan
- Reset, then a single row with first=last=1 and psum columns 1,2,3,4 at cycles 0..3 → out_valid_out rises at cycle 4 with data {1,2,3,4}. Hold out_ready_in=1 for one cycle → out_valid_out falls.
- Three-tile accumulation: rows of 200 per column (first), then 200, then 200 (last) → single output row of 600 per column. No output for the first two rows.
- Wrap: ACC_WIDTH=16, 300 rows of 255 from first to last → element = 76500 mod 65536 = 10964.
- Back-pressure: out_ready_in=0, five consecutive first+last rows → full_out high after the 4th push, the 5th is dropped, overflow_out=1. Then drain 4 rows in order, with overflow_out staying 1.
- Full with simultaneous pop: FIFO full, out_ready_in=1 in the same cycle a last row completes → row accepted, count stays 4, overflow_out stays 0.
- Reset asserted mid-skew (cycle 2 of a row) → after release, no output appears and all outputs are 0.

Source files
------------

// File: rtl/psum_collector.sv
// psum_collector: deskews bottom-row partial sums, accumulates tiles and buffers completed rows in a FIFO
module psum_collector #(
   parameter int WIDTH     = 8,
   parameter int COLS      = 4,
   parameter int ACC_WIDTH = 16,
   parameter int DEPTH     = 4
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic [COLS*WIDTH-1:0]     psum_in,
   input  logic                      valid_in,
   input  logic                      first_in,
   input  logic                      last_in,
   output logic [COLS*ACC_WIDTH-1:0] out_data_out,
   output logic                      out_valid_out,
   input  logic                      out_ready_in,
   output logic                      full_out,
   output logic                      overflow_out
);
   localparam int AW = $clog2(DEPTH);
   logic [COLS*WIDTH-1:0]     col;
   logic [2:0]                fl [COLS-1];
   logic                      a_v, a_f, a_l;
   logic [ACC_WIDTH-1:0]      acc [COLS];
   logic [ACC_WIDTH-1:0]      sum [COLS];
   logic [COLS*ACC_WIDTH-1:0] row;
   logic [COLS*ACC_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]             rd, wr;
   logic [AW:0]               cnt;
   logic                      pop, done, push;
   // column j arrives j cycles after launch, so it waits COLS-1-j cycles to line up with the last column
   for (genvar j = 0; j < COLS; j++) begin : g_col
      if (j == COLS-1) begin : g_direct
         assign col[j*WIDTH +: WIDTH] = psum_in[j*WIDTH +: WIDTH];
      end else begin : g_dly
         logic [WIDTH-1:0] sr [COLS-1-j];
         always_ff @(posedge clk_in) begin
            if (rst_in) begin
               for (int k = 0; k < COLS-1-j; k++) sr[k] <= '0;
            end else begin
               sr[0] <= psum_in[j*WIDTH +: WIDTH];
               for (int k = 1; k < COLS-1-j; k++) sr[k] <= sr[k-1];
            end
         end
         assign col[j*WIDTH +: WIDTH] = sr[COLS-2-j];
      end
   end
   assign {a_v, a_f, a_l} = fl[COLS-2];
   always_comb begin
      row = '0;
      for (int j = 0; j < COLS; j++) begin
         sum[j] = (a_f ? '0 : acc[j]) + ACC_WIDTH'(col[j*WIDTH +: WIDTH]);
         row[j*ACC_WIDTH +: ACC_WIDTH] = sum[j];
      end
   end
   assign out_valid_out = cnt != '0;
   assign full_out      = cnt == (AW+1)'(DEPTH);
   assign out_data_out  = out_valid_out ? mem[rd] : '0;
   assign pop           = out_valid_out & out_ready_in;
   assign done          = a_v & a_l;
   assign push          = done & (~full_out | pop);
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int k = 0; k < COLS-1; k++) fl[k] <= '0;
         for (int j = 0; j < COLS; j++) acc[j] <= '0;
         rd           <= '0;
         wr           <= '0;
         cnt          <= '0;
         overflow_out <= 1'b0;
      end else begin
         fl[0] <= {valid_in, valid_in & first_in, valid_in & last_in};
         for (int k = 1; k < COLS-1; k++) fl[k] <= fl[k-1];
         if (a_v) for (int j = 0; j < COLS; j++) acc[j] <= sum[j];
         if (push) wr <= wr + AW'(1);
         if (pop) rd <= rd + AW'(1);
         cnt          <= cnt + (AW+1)'(push) - (AW+1)'(pop);
         overflow_out <= overflow_out | (done & ~push);
      end
   end
   // storage needs no reset: the head is masked to zero whenever the FIFO is empty
   always_ff @(posedge clk_in) if (push) mem[wr] <= row;
endmodule
